// File: rtl/boot_load_ctrl_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, image header
// field positions and the header sanity check.
package boot_load_ctrl_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_HDR,
    LDR_LOAD_D,
    LDR_LOAD_I,
    LDR_RELEASE,
    LDR_RUN,
    LDR_ERR
  } ldr_state_e;

  // Header beat layout: instruction count in the upper half, data count in the lower.
  localparam int LDR_HDR_NI_MSB = 31;
  localparam int LDR_HDR_NI_LSB = 16;
  localparam int LDR_HDR_ND_MSB = 15;
  localparam int LDR_HDR_ND_LSB = 0;

  // An image needs at least one instruction and must fit in both memories.
  function automatic logic hdr_invalid(input logic [15:0] n_instr,
                                       input logic [15:0] n_data,
                                       input int          max_words);
    return (n_instr == 16'd0) ||
           (32'(n_instr) > max_words) ||
           (32'(n_data) > max_words);
  endfunction

endpackage

// File: rtl/boot_load_ctrl.sv
// Boot sequencer: streams a program image into data and instruction BRAM,
// then releases the rv32i core and hands it the data-BRAM write port.
module boot_load_ctrl
  import boot_load_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [DATA_WIDTH-1:0] s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  rd_enbl,
  output logic                  i_r_enb,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  ldr_state_e            state;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      n_data;
  logic [CNT_W-1:0]      n_instr;
  logic [15:0]           hdr_ni;
  logic [15:0]           hdr_nd;
  logic                  beat;
  logic                  last_d;
  logic                  last_i;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign s_ready = (state == LDR_HDR) || (state == LDR_LOAD_D) || (state == LDR_LOAD_I);
  assign busy    = s_ready || (state == LDR_RELEASE);
  assign err     = (state == LDR_ERR);
  assign beat    = s_valid && s_ready;

  assign hdr_ni    = s_dat[LDR_HDR_NI_MSB:LDR_HDR_NI_LSB];
  assign hdr_nd    = s_dat[LDR_HDR_ND_MSB:LDR_HDR_ND_LSB];
  assign word_addr = ADDR_WIDTH'({word_cnt, 2'b00});
  assign last_d    = (word_cnt == n_data - CNT_W'(1));
  assign last_i    = (word_cnt == n_instr - CNT_W'(1));

  // One shared word counter serves both memories; it restarts on each phase change.
  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= LDR_IDLE;
      word_cnt         <= '0;
      n_data           <= '0;
      n_instr          <= '0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      d_bram_init_done <= 1'b0;
      pc_stall         <= 1'b1;
      rd_enbl          <= 1'b0;
      i_r_enb          <= 1'b0;
    end else begin
      i_w_enb <= 1'b0;
      d_w_enb <= 1'b0;
      case (state)
        LDR_IDLE: begin
          if (start) begin
            state            <= LDR_HDR;
            d_bram_init_done <= 1'b0;
          end
        end
        LDR_HDR: begin
          if (beat) begin
            word_cnt <= '0;
            n_instr  <= CNT_W'(hdr_ni);
            n_data   <= CNT_W'(hdr_nd);
            if (hdr_invalid(hdr_ni, hdr_nd, MAX_WORDS)) state <= LDR_ERR;
            else if (hdr_nd == 16'd0)                   state <= LDR_LOAD_I;
            else                                        state <= LDR_LOAD_D;
          end
        end
        LDR_LOAD_D: begin
          if (beat) begin
            d_w_addr <= word_addr;
            d_w_dat  <= s_dat;
            d_w_enb  <= 1'b1;
            if (last_d) begin
              word_cnt <= '0;
              state    <= LDR_LOAD_I;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        LDR_LOAD_I: begin
          if (beat) begin
            i_w_addr <= word_addr;
            i_w_dat  <= s_dat;
            i_w_enb  <= 1'b1;
            if (last_i) begin
              word_cnt         <= '0;
              state            <= LDR_RELEASE;
              d_bram_init_done <= 1'b1;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        // Single settle cycle lets the final instruction write land before the first fetch.
        LDR_RELEASE: begin
          state    <= LDR_RUN;
          pc_stall <= 1'b0;
          rd_enbl  <= 1'b1;
          i_r_enb  <= 1'b1;
        end
        LDR_RUN: begin
          if (halt) begin
            state    <= LDR_IDLE;
            pc_stall <= 1'b1;
            rd_enbl  <= 1'b0;
            i_r_enb  <= 1'b0;
          end
        end
        LDR_ERR: begin
          if (start) begin
            state            <= LDR_HDR;
            d_bram_init_done <= 1'b0;
          end
        end
        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Self-checking bench for boot_load_ctrl: images are streamed with random
// throttling and every BRAM write is compared against an image-derived model.
module tb_boot_load_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          halt;
  logic [DW-1:0] s_dat;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] i_w_addr;
  logic [DW-1:0] i_w_dat;
  logic          i_w_enb;
  logic [AW-1:0] d_w_addr;
  logic [DW-1:0] d_w_dat;
  logic          d_w_enb;
  logic          d_bram_init_done;
  logic          pc_stall;
  logic          rd_enbl;
  logic          i_r_enb;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  boot_load_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall),
    .rd_enbl(rd_enbl), .i_r_enb(i_r_enb), .busy(busy), .err(err)
  );

  typedef struct {
    bit            is_i;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    int            cyc;
  } wr_t;

  wr_t         wr_q[$];
  wr_t         exp_q[$];
  int          acc_q[$];
  logic [31:0] img_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write pulse with the cycle (edge number) it became visible.
  always @(negedge clk) begin
    wr_t w;
    if (d_w_enb === 1'b1) begin
      w.is_i = 1'b0; w.addr = d_w_addr; w.dat = d_w_dat; w.cyc = cyc;
      wr_q.push_back(w);
    end
    if (i_w_enb === 1'b1) begin
      w.is_i = 1'b1; w.addr = i_w_addr; w.dat = i_w_dat; w.cyc = cyc;
      wr_q.push_back(w);
    end
  end

  // Reference: data word k goes to data byte address 4k, instruction word k to
  // instruction byte address 4k, each visible the cycle after its beat was taken.
  function automatic void build_expect();
    wr_t e;
    int  nd = int'(img_q[0][15:0]);
    int  ni = int'(img_q[0][31:16]);
    exp_q.delete();
    for (int k = 0; k < nd + ni; k++) begin
      e.is_i = (k >= nd);
      e.addr = AW'(4 * (e.is_i ? k - nd : k));
      e.dat  = img_q[1 + k];
      e.cyc  = (acc_q.size() > 1 + k) ? acc_q[1 + k] : -1;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void make_image(input int nd, input int ni);
    img_q.delete();
    img_q.push_back({16'(ni), 16'(nd)});
    for (int k = 0; k < nd + ni; k++) img_q.push_back($urandom());
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_halt();
    @(negedge clk); halt = 1'b1;
    @(negedge clk); halt = 1'b0;
  endtask

  // Streams n_beats of img_q; pct < 0 toggles s_valid every other cycle.
  task automatic feed(input int pct, input int n_beats, input bit noise);
    int b = 0;
    int budget = 5000;
    acc_q.delete();
    while (b < n_beats && budget > 0) begin
      s_valid = (pct < 0) ? ((cyc % 2) != 0) : ($urandom_range(99) < pct);
      s_dat   = s_valid ? img_q[b] : $urandom();
      if (noise) begin
        start = ($urandom_range(9) == 0);
        halt  = ($urandom_range(9) == 0);
      end
      if (s_valid && s_ready) begin
        acc_q.push_back(cyc + 1);
        b++;
      end
      @(negedge clk);
      budget--;
    end
    s_valid = 1'b0; start = 1'b0; halt = 1'b0;
    n_cmp++;
    if (budget == 0) begin
      n_bad++;
      $display("FAIL feed_timeout: accepted %0d beats, want %0d", b, n_beats);
    end
  endtask

  task automatic test_reset();
    logic [92:0] want;
    want = {1'b0, 10'd0, 32'd0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1; start = 1'b0; halt = 1'b0; s_valid = 1'b0; s_dat = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb, d_bram_init_done,
         pc_stall, rd_enbl, i_r_enb, busy, err} !== want) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", {s_ready, i_w_addr, i_w_dat, i_w_enb,
               d_w_addr, d_w_dat, d_w_enb, d_bram_init_done, pc_stall, rd_enbl, i_r_enb,
               busy, err}, want);
    end
    rst = 1'b0;
    wr_q.delete();
    s_valid = 1'b1; s_dat = 32'h0002_0003; halt = 1'b1;
    repeat (3) @(negedge clk);
    s_valid = 1'b0; halt = 1'b0;
    n_cmp++;
    if ({busy, s_ready, pc_stall, wr_q.size()} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL idle_ignores: busy=%b s_ready=%b pc_stall=%b writes=%0d want 0 0 1 0",
               busy, s_ready, pc_stall, wr_q.size());
    end
  endtask

  task automatic test_basic();
    wr_q.delete();
    img_q.delete();
    img_q = '{32'h0002_0003, 32'h11, 32'h22, 32'h33, 32'hA0, 32'hA1};
    pulse_start();
    n_cmp++;
    if ({busy, s_ready, d_bram_init_done} !== 3'b110) begin
      n_bad++;
      $display("FAIL basic_hdr: busy,s_ready,init_done=%b want 110",
               {busy, s_ready, d_bram_init_done});
    end
    feed(100, 6, 1'b0);
    s_valid = 1'b1; s_dat = 32'hDEAD_BEEF;
    n_cmp++;
    if ({busy, s_ready, pc_stall, rd_enbl, i_r_enb, d_bram_init_done} !== 6'b101001) begin
      n_bad++;
      $display("FAIL basic_release: busy,rdy,stall,rd,ir,init=%b want 101001",
               {busy, s_ready, pc_stall, rd_enbl, i_r_enb, d_bram_init_done});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, s_ready, pc_stall, rd_enbl, i_r_enb, d_bram_init_done} !== 6'b000111) begin
      n_bad++;
      $display("FAIL basic_run: busy,rdy,stall,rd,ir,init=%b want 000111",
               {busy, s_ready, pc_stall, rd_enbl, i_r_enb, d_bram_init_done});
    end
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    build_expect();
    n_cmp++;
    if (wr_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if ({wr_q[i].is_i, wr_q[i].addr, wr_q[i].dat, wr_q[i].cyc} !==
          {exp_q[i].is_i, exp_q[i].addr, exp_q[i].dat, exp_q[i].cyc}) begin
        n_bad++;
        $display("FAIL basic_wr[%0d]: got i=%b a=%0d d=%h c=%0d want i=%b a=%0d d=%h c=%0d", i,
                 wr_q[i].is_i, wr_q[i].addr, wr_q[i].dat, wr_q[i].cyc,
                 exp_q[i].is_i, exp_q[i].addr, exp_q[i].dat, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_halt();
    @(negedge clk); start = 1'b1; halt = 1'b1;
    @(negedge clk); start = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, s_ready, err, pc_stall, rd_enbl, i_r_enb, d_bram_init_done} !== 7'b0001001) begin
      n_bad++;
      $display("FAIL halt_wins: busy,rdy,err,stall,rd,ir,init=%b want 0001001",
               {busy, s_ready, err, pc_stall, rd_enbl, i_r_enb, d_bram_init_done});
    end
  endtask

  task automatic test_no_data();
    int run_cyc = -1;
    wr_q.delete();
    img_q = '{32'h0001_0000, 32'h0050_0293};
    pulse_start();
    n_cmp++;
    if (d_bram_init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL nodata_init_drop: got %b want 0", d_bram_init_done);
    end
    feed(100, 2, 1'b0);
    for (int k = 0; k < 4 && run_cyc < 0; k++) begin
      if (pc_stall === 1'b0) run_cyc = cyc;
      else @(negedge clk);
    end
    n_cmp++;
    if (acc_q.size() != 2 || run_cyc != acc_q[0] + 2) begin
      n_bad++;
      $display("FAIL nodata_run_time: got edge %0d want header edge + 2", run_cyc);
    end
    build_expect();
    n_cmp++;
    if (wr_q.size() != 1 || exp_q.size() != 1 ||
        {wr_q[0].is_i, wr_q[0].addr, wr_q[0].dat, wr_q[0].cyc} !==
        {exp_q[0].is_i, exp_q[0].addr, exp_q[0].dat, exp_q[0].cyc}) begin
      n_bad++;
      $display("FAIL nodata_write: got %0d writes, want one instr write of 00500293 at 0",
               wr_q.size());
    end
    do_halt();
  endtask

  task automatic test_hdr_errors();
    logic [31:0] bad_hdr[3];
    bad_hdr = '{32'h0000_0004, 32'h0101_0000, 32'h0001_0101};
    wr_q.delete();
    for (int h = 0; h < 3; h++) begin
      pulse_start();
      n_cmp++;
      if ({err, busy, s_ready} !== 3'b011) begin
        n_bad++;
        $display("FAIL err_restart[%0d]: err,busy,rdy=%b want 011", h, {err, busy, s_ready});
      end
      img_q = '{bad_hdr[h]};
      feed(100, 1, 1'b0);
      s_valid = 1'b1; s_dat = 32'h0000_0001;
      @(negedge clk);
      s_valid = 1'b0;
      n_cmp++;
      if ({err, s_ready, pc_stall, busy} !== 4'b1010) begin
        n_bad++;
        $display("FAIL err_state[%0d]: err,rdy,stall,busy=%b want 1010", h,
                 {err, s_ready, pc_stall, busy});
      end
    end
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL err_no_writes: got %0d writes want 0", wr_q.size());
    end
    pulse_start();
    n_cmp++;
    if ({err, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL err_exit: err,busy=%b want 01", {err, busy});
    end
  endtask

  // Runs a full load with checking; pct < 0 toggles s_valid.
  task automatic test_load(input string name, input int nd, input int ni, input int pct,
                           input bit noise);
    wr_q.delete();
    make_image(nd, ni);
    pulse_start();
    feed(pct, 1 + nd + ni, noise);
    @(negedge clk);
    n_cmp++;
    if ({pc_stall, rd_enbl, i_r_enb, d_bram_init_done, busy} !== 5'b01110) begin
      n_bad++;
      $display("FAIL %s_run: stall,rd,ir,init,busy=%b want 01110", name,
               {pc_stall, rd_enbl, i_r_enb, d_bram_init_done, busy});
    end
    build_expect();
    n_cmp++;
    if (wr_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_wr_count: got %0d want %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if ({wr_q[i].is_i, wr_q[i].addr, wr_q[i].dat, wr_q[i].cyc} !==
          {exp_q[i].is_i, exp_q[i].addr, exp_q[i].dat, exp_q[i].cyc}) begin
        n_bad++;
        $display("FAIL %s_wr[%0d]: got i=%b a=%0d d=%h c=%0d want i=%b a=%0d d=%h c=%0d",
                 name, i, wr_q[i].is_i, wr_q[i].addr, wr_q[i].dat, wr_q[i].cyc,
                 exp_q[i].is_i, exp_q[i].addr, exp_q[i].dat, exp_q[i].cyc);
      end
    end
    do_halt();
  endtask

  task automatic test_reset_mid();
    wr_q.delete();
    make_image(2, 4);
    pulse_start();
    feed(100, 4, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, pc_stall, i_w_enb, d_bram_init_done, s_ready, err} !== 6'b010000) begin
      n_bad++;
      $display("FAIL rst_mid_async: busy,stall,iwe,init,rdy,err=%b want 010000",
               {busy, pc_stall, i_w_enb, d_bram_init_done, s_ready, err});
    end
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b1; s_dat = img_q[4];
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    n_cmp++;
    if ({busy, pc_stall, i_w_enb, d_w_enb} !== 4'b0100) begin
      n_bad++;
      $display("FAIL rst_mid_idle: busy,stall,iwe,dwe=%b want 0100",
               {busy, pc_stall, i_w_enb, d_w_enb});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt();
    test_no_data();
    test_hdr_errors();
    test_load("max", MW, MW, 80, 1'b1);
    test_load("toggle", 2, 3, -1, 1'b0);
    test_reset_mid();
    for (int r = 0; r < 6; r++)
      test_load("rand", $urandom_range(12), 1 + $urandom_range(11),
                30 + $urandom_range(70), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
